// File: rtl/sr_flag_arbiter_if.sv
// Request/response bundle between the control requesters and the flag arbiter.
// Packed per-requester fields: requester k owns cmd[2k+1:2k] and idx[k*IDXW +: IDXW].
interface sr_flag_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
);
  localparam int GIDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    cmd;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0]      ack;
  logic [GIDW-1:0]      grant_id;
  logic                 busy;
  logic                 err;
  logic [NFLAG-1:0]     q;

  modport master (output req, cmd, idx, input ack, grant_id, busy, err, q);
  modport slave  (input req, cmd, idx, output ack, grant_id, busy, err, q);
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter applying one {s,r} command per 3 cycles to a shared bank of SR flags.
// Define SR_TOGGLE_EN to make cmd 11 toggle the flag; otherwise 11 is rejected with err.
module sr_flag_arbiter #(
  parameter int NREQ  = 2,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  sr_flag_arbiter_if.slave  bus
);
  localparam int GIDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

  state_t           state_q, state_d;
  logic [GIDW-1:0]  rr_q, rr_d;
  logic [GIDW-1:0]  gid_q, gid_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [NFLAG-1:0] q_q, q_d;
  logic             err_q, err_d;

  logic             found;
  logic [GIDW-1:0]  win;
  logic [NFLAG-1:0] sel;
  logic             bad_idx;

  // Search starts one past the last winner so every waiting requester is reached within NREQ-1 grants.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && bus.req[k] && (k == (int'(rr_q) + off) % NREQ)) begin
          found = 1'b1;
          win   = GIDW'(k);
        end
      end
    end
  end

  // One-hot flag select; an out-of-range index selects nothing, so q cannot change.
  always_comb begin
    sel     = '0;
    bad_idx = (int'(idx_q) >= NFLAG);
    for (int i = 0; i < NFLAG; i++) begin
      sel[i] = (int'(idx_q) == i);
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    q_d     = q_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = APPLY;
          rr_d    = win;
          gid_d   = win;
          cmd_d   = bus.cmd[2*int'(win) +: 2];
          idx_d   = bus.idx[int'(win)*IDXW +: IDXW];
        end
      end
      APPLY: begin
        state_d = ACK;
        err_d   = bad_idx;
        case (cmd_q)
          2'b10:   q_d = q_q | sel;
          2'b01:   q_d = q_q & ~sel;
          2'b11: begin
`ifdef SR_TOGGLE_EN
            q_d = q_q ^ sel;
`else
            err_d = 1'b1;
`endif
          end
          default: q_d = q_q;
        endcase
      end
      ACK: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= GIDW'(NREQ - 1);
      gid_q   <= '0;
      cmd_q   <= '0;
      idx_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  // ack decodes from state so an asynchronous reset removes it without waiting for a clock.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      bus.ack[k] = (state_q == ACK) && (int'(gid_q) == k);
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;
  assign bus.q        = q_q;
  assign bus.grant_id = gid_q;
endmodule
